mmio_out_port: RTL and testbench

MMIO_OUT_PORT -- requirements
Module: mmio_out_port

---
 rtl/mmio_pkg.sv | 32 +++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/mmio_out_port.sv | 70 +++++++
 tb/tb_mmio_out_port.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Register map and bit positions shared by the memory-mapped output port.
package mmio_pkg;

  typedef enum logic [1:0] {
    RegData   = 2'd0,
    RegStatus = 2'd1,
    RegCtrl   = 2'd2
  } reg_off_e;

  localparam int unsigned StatusFullBit  = 0;
  localparam int unsigned StatusEmptyBit = 1;
  localparam int unsigned StatusOvfBit   = 2;
  localparam int unsigned StatusCountLsb = 4;
  localparam int unsigned StatusCountMsb = 8;

  localparam int unsigned CtrlFlushBit  = 0;
  localparam int unsigned CtrlClrOvfBit = 1;

  function automatic logic [15:0] status_word(input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [4:0] count);
    logic [15:0] s;
    s                                = '0;
    s[StatusFullBit]                 = full;
    s[StatusEmptyBit]                = empty;
    s[StatusOvfBit]                  = ovf;
    s[StatusCountMsb:StatusCountLsb] = count;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: unreset storage, reset pointers/count, flush overrides push and pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Gated to zero when empty so the head word is never stale storage.
  assign rdata = empty ? '0 : mem[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_out_port.sv
// CPU-writable output port: DATA pushes into a FIFO drained by a valid/ready consumer.
module mmio_out_port
  import mmio_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h6001,
  parameter int unsigned DEPTH     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] rdata,
  output logic        hit,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [14:0]     offset;
  logic            data_wr, ctrl_wr, status_rd;
  logic            fifo_full, fifo_empty, xfer;
  logic [CntW-1:0] fifo_count;
  logic            ovf_q, ovf_d;

  assign offset    = addressM - BASE_ADDR;
  assign hit       = (offset < 15'd3);
  assign data_wr   = writeM && hit && (offset[1:0] == RegData);
  assign ctrl_wr   = writeM && hit && (offset[1:0] == RegCtrl);
  assign status_rd = hit && (offset[1:0] == RegStatus);

  assign tx_valid = !fifo_empty;
  assign xfer     = tx_valid && tx_ready;

  sync_fifo #(
    .WIDTH(16),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(reset),
    .push (data_wr),
    .pop  (xfer),
    .flush(ctrl_wr && outM[CtrlFlushBit]),
    .wdata(outM),
    .rdata(tx_data),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // Overflow only when the word is really dropped; a same-cycle pop makes room.
  always_comb begin
    ovf_d = ovf_q;
    if (ctrl_wr && outM[CtrlClrOvfBit]) ovf_d = 1'b0;
    if (data_wr && fifo_full && !xfer)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  always_comb begin
    rdata = '0;
    if (status_rd) rdata = status_word(fifo_full, fifo_empty, ovf_q, 5'(fifo_count));
  end

endmodule

// File: tb/tb_mmio_out_port.sv
// Randomized bench for mmio_out_port: queue-based FIFO model with a separate drain monitor.
module tb_mmio_out_port;

  localparam logic [14:0] DATA_A = 15'h6001;
  localparam logic [14:0] STAT_A = 15'h6002;
  localparam logic [14:0] CTRL_A = 15'h6003;
  localparam int          DEPTH  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [14:0] addressM = '0;
  logic [15:0] outM = '0;
  logic        writeM = 1'b0;
  logic [15:0] rdata;
  logic        hit;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  logic [15:0] exp_q[$];
  logic        m_ovf = 1'b0;
  logic        flushing = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  mmio_out_port #(
    .BASE_ADDR(DATA_A),
    .DEPTH    (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addressM(addressM),
    .outM    (outM),
    .writeM  (writeM),
    .rdata   (rdata),
    .hit     (hit),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] model_status();
    logic [15:0] s;
    s      = '0;
    s[0]   = (exp_q.size() == DEPTH);
    s[1]   = (exp_q.size() == 0);
    s[2]   = m_ovf;
    s[8:4] = 5'(exp_q.size());
    return s;
  endfunction

  // Entered just after a rising edge; returns just after the following rising edge.
  task automatic cycle(input logic w, input logic [14:0] a, input logic [15:0] d,
                       input logic rdy);
    logic        is_push, is_ctrl, accept, drop;
    logic [15:0] exp_rd;
    logic        exp_hit;
    writeM   = w;
    addressM = a;
    outM     = d;
    tx_ready = rdy;
    is_push  = w && (a == DATA_A);
    is_ctrl  = w && (a == CTRL_A);
    accept   = is_push && !(exp_q.size() == DEPTH && !rdy);
    drop     = is_push && !accept;
    flushing = is_ctrl && d[0];
    exp_hit  = (a >= DATA_A) && (a <= CTRL_A);
    exp_rd   = (a == STAT_A) ? model_status() : 16'h0000;
    #1;
    check("hit", 32'(hit), 32'(exp_hit));
    check("rdata", 32'(rdata), 32'(exp_rd));
    @(posedge clk);
    #1;
    if (flushing) exp_q.delete();
    if (accept) exp_q.push_back(d);
    if (is_ctrl && d[1]) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    flushing = 1'b0;
    writeM   = 1'b0;
  endtask

  task automatic lit_status(input logic [15:0] v);
    writeM   = 1'b0;
    addressM = STAT_A;
    #1;
    check("status_literal", 32'(rdata), 32'(v));
  endtask

  task automatic async_reset();
    writeM   = 1'b0;
    tx_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("reset_valid_immediate", 32'(tx_valid), 32'd0);
    check("reset_data_immediate", 32'(tx_data), 32'd0);
    exp_q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    check("reset_valid_held", 32'(tx_valid), 32'd0);
    reset = 1'b1;
  endtask

  // Monitor: a transfer at the coming edge pops the expected head.
  always @(negedge clk) begin
    if (reset) begin
      check("tx_valid", 32'(tx_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("tx_data", 32'(tx_data), 32'(exp_q[0]));
        if (tx_ready && !flushing) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [14:0] a;
    logic        rdy;
    int          r;
    #3;
    check("por_valid", 32'(tx_valid), 32'd0);
    check("por_data", 32'(tx_data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    lit_status(16'h0002);

    // Single push, one-cycle latency, single-cycle valid.
    cycle(1'b1, DATA_A, 16'd1234, 1'b1);
    cycle(1'b0, STAT_A, 16'h0, 1'b1);
    cycle(1'b0, STAT_A, 16'h0, 1'b1);
    lit_status(16'h0002);

    // Fill, overflow drop, backpressured drain.
    for (int i = 1; i <= 8; i++) cycle(1'b1, DATA_A, 16'(i), 1'b0);
    lit_status(16'h0081);
    cycle(1'b1, DATA_A, 16'd99, 1'b0);
    lit_status(16'h0085);
    cycle(1'b0, STAT_A, 16'h0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, STAT_A, 16'h0, 1'b1);
    lit_status(16'h0006);
    cycle(1'b1, CTRL_A, 16'h0002, 1'b0);
    lit_status(16'h0002);

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 8; i++) cycle(1'b1, DATA_A, 16'(100 + i), 1'b0);
    cycle(1'b1, DATA_A, 16'd42, 1'b1);
    lit_status(16'h0081);
    for (int i = 0; i < 9; i++) cycle(1'b0, STAT_A, 16'h0, 1'b1);
    lit_status(16'h0002);

    // Flush and clear with three words queued and overflow set; flush beats the pop.
    for (int i = 1; i <= 8; i++) cycle(1'b1, DATA_A, 16'(200 + i), 1'b0);
    cycle(1'b1, DATA_A, 16'd77, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, STAT_A, 16'h0, 1'b1);
    lit_status(16'h0034);
    cycle(1'b1, CTRL_A, 16'h0003, 1'b1);
    lit_status(16'h0002);
    cycle(1'b0, STAT_A, 16'h0, 1'b1);

    // Asynchronous reset mid-stream.
    for (int i = 1; i <= 5; i++) cycle(1'b1, DATA_A, 16'(300 + i), 1'b0);
    async_reset();
    lit_status(16'h0002);
    cycle(1'b1, DATA_A, 16'hBEEF, 1'b1);
    cycle(1'b0, STAT_A, 16'h0, 1'b1);

    // Decode: out-of-range and status writes, reads of write-only registers.
    cycle(1'b1, 15'h6000, 16'h1111, 1'b1);
    cycle(1'b1, 15'h6002, 16'h2222, 1'b1);
    cycle(1'b1, 15'h6004, 16'h3333, 1'b1);
    cycle(1'b0, 15'h6001, 16'h0, 1'b1);
    cycle(1'b0, 15'h6003, 16'h0, 1'b1);
    lit_status(16'h0002);

    // Randomized traffic with bursty backpressure.
    rdy = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if (n % 16 == 0) r = $urandom_range(0, 2);
      rdy = (r == 0) ? 1'b0 : (r == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      a = 15'(int'(DATA_A) - 1 + $urandom_range(0, 4));
      case ($urandom_range(0, 99)) inside
        [0:49]:  cycle(1'b1, DATA_A, 16'($urandom), rdy);
        [50:52]: cycle(1'b1, CTRL_A, 16'($urandom_range(0, 3)), rdy);
        [53:59]: cycle(1'b1, (a == DATA_A || a == CTRL_A) ? STAT_A : a, 16'($urandom), rdy);
        default: cycle(1'b0, a, 16'h0, rdy);
      endcase
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, STAT_A, 16'h0, 1'b1);
    lit_status(model_status());
    check("final_empty", 32'(tx_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
